pll_profile_scheduler: RTL

- Shares the single reconfigurable PLL and its four configuration ROM profiles among up to NUM_REQ requesters.
- Arbitrates requests round-robin and drives the reconfig circuit handshake: address reset, ROM write, reconfig, then lock wait.
- Reports completion or timeout per grant.
- Sits beside the PLL reconfig circuit and ROM mux, and replaces direct manual control of want_to_reconfig/intended_rom.

---
 rtl/pll_profile_scheduler_pkg.sv | 22 ++
 rtl/pll_profile_scheduler_rr_arbiter.sv | 31 +++
 rtl/pll_profile_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pll_profile_scheduler_pkg.sv
// Shared types and defaults for the PLL profile scheduler: FSM state encoding,
// ROM profile width and default timeout values.
package pll_sched_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RST_ADDR  = 4'd1,
        WRITE     = 4'd2,
        WAIT_WR   = 4'd3,
        RECONF    = 4'd4,
        WAIT_RC   = 4'd5,
        WAIT_LOCK = 4'd6,
        DONE      = 4'd7,
        ERR       = 4'd8
    } sched_state_e;

    localparam int PROFILE_W        = 2;
    localparam int DEF_BUSY_TIMEOUT = 1024;
    localparam int DEF_LOCK_TIMEOUT = 65535;
    localparam int DEF_LOCK_STABLE  = 64;

endpackage

// File: rtl/pll_profile_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping,
// and returns it both one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic [IW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k >= N) ? IW'(int'(ptr) + k - N) : IW'(int'(ptr) + k);
            if (!vld && req[pos]) begin
                vld      = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_profile_scheduler.sv
// Shares one reconfigurable PLL among NUM_REQ requesters: round-robin grant,
// reconfig-circuit handshake, lock qualification and completion/timeout report.
module pll_profile_scheduler
    import pll_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       req_profile,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       done,
    output logic                       error,
    output logic [PROFILE_W-1:0]       mux_sel,
    output logic                       reset_rom_address,
    output logic                       write_from_rom,
    output logic                       reconfig,
    input  logic                       busy,
    input  logic                       locked,
    output logic [PROFILE_W-1:0]       current_profile,
    output logic                       profile_valid,
    output logic [3:0]                 current_state
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMAX = (LOCK_TIMEOUT > BUSY_TIMEOUT) ? LOCK_TIMEOUT : BUSY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int LW   = $clog2(LOCK_STABLE + 1);

    sched_state_e         state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PROFILE_W-1:0] profile_q, profile_d;
    logic [PROFILE_W-1:0] cur_prof_q, cur_prof_d;
    logic                 pvalid_q, pvalid_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
    logic                 seen_busy_q, seen_busy_d;
    logic                 rra_q, rra_d, wr_q, wr_d, rc_q, rc_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 locked_meta_q, locked_meta_d, locked_s_q, locked_s_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;
    logic [PROFILE_W-1:0] arb_prof;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign arb_prof = req_profile[{arb_idx, 1'b0} +: PROFILE_W];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        profile_d     = profile_q;
        cur_prof_d    = cur_prof_q;
        pvalid_d      = pvalid_q;
        tmo_d         = tmo_q + TW'(1);
        lock_cnt_d    = lock_cnt_q;
        seen_busy_d   = seen_busy_q;
        locked_meta_d = locked;
        locked_s_d    = locked_meta_q;
        // Strobes are a registered decode of the state just left, so each one
        // lasts exactly one cycle and at most one can be high at a time.
        rra_d         = (state_q == RST_ADDR);
        wr_d          = (state_q == WRITE);
        rc_d          = (state_q == RECONF);
        done_d        = (state_q == DONE);
        err_d         = (state_q == ERR);

        case (state_q)
            IDLE: begin
                if (pvalid_q && !locked_s_q) pvalid_d = 1'b0;
                if (arb_vld) begin
                    grant_d   = arb_gnt;
                    profile_d = arb_prof;
                    ptr_d     = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d   = (pvalid_q && locked_s_q && arb_prof == cur_prof_q) ? DONE : RST_ADDR;
                end
            end
            RST_ADDR: state_d = WRITE;
            WRITE:    state_d = WAIT_WR;
            WAIT_WR, WAIT_RC: begin
                if (busy) seen_busy_d = 1'b1;
                if (seen_busy_q && !busy)
                    state_d = (state_q == WAIT_WR) ? RECONF : WAIT_LOCK;
                else if (tmo_q == TW'(BUSY_TIMEOUT))
                    state_d = ERR;
            end
            RECONF: begin
                pvalid_d = 1'b0;
                state_d  = WAIT_RC;
            end
            WAIT_LOCK: begin
                lock_cnt_d = locked_s_q ? lock_cnt_q + LW'(1) : '0;
                if (locked_s_q && lock_cnt_q == LW'(LOCK_STABLE - 1)) begin
                    cur_prof_d = profile_q;
                    pvalid_d   = 1'b1;
                    state_d    = DONE;
                end else if (tmo_q == TW'(LOCK_TIMEOUT)) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            ERR: begin
                grant_d  = '0;
                pvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tmo_d       = '0;
            lock_cnt_d  = '0;
            seen_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            profile_q     <= '0;
            cur_prof_q    <= '0;
            pvalid_q      <= 1'b0;
            tmo_q         <= '0;
            lock_cnt_q    <= '0;
            seen_busy_q   <= 1'b0;
            rra_q         <= 1'b0;
            wr_q          <= 1'b0;
            rc_q          <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            profile_q     <= profile_d;
            cur_prof_q    <= cur_prof_d;
            pvalid_q      <= pvalid_d;
            tmo_q         <= tmo_d;
            lock_cnt_q    <= lock_cnt_d;
            seen_busy_q   <= seen_busy_d;
            rra_q         <= rra_d;
            wr_q          <= wr_d;
            rc_q          <= rc_d;
            done_q        <= done_d;
            err_q         <= err_d;
            locked_meta_q <= locked_meta_d;
            locked_s_q    <= locked_s_d;
        end
    end

    assign grant             = grant_q;
    assign done              = done_q;
    assign error             = err_q;
    assign mux_sel           = profile_q;
    assign reset_rom_address = rra_q;
    assign write_from_rom    = wr_q;
    assign reconfig          = rc_q;
    assign current_profile   = cur_prof_q;
    assign profile_valid     = pvalid_q;
    assign current_state     = state_q;

endmodule
